// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two client request/response channels plus the
// put/get channels toward the memory wrapper.
interface mem_arbiter_if #(
  parameter int unsigned REQ_W = 68
);
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [REQ_W-1:0] imem_req;
  logic             imem_resp_valid;
  logic             imem_resp_ready;
  logic [REQ_W-1:0] imem_resp;

  logic             dmem_req_valid;
  logic             dmem_req_ready;
  logic [REQ_W-1:0] dmem_req;
  logic             dmem_resp_valid;
  logic             dmem_resp_ready;
  logic [REQ_W-1:0] dmem_resp;

  logic             put_valid;
  logic             put_ready;
  logic [REQ_W-1:0] put_request;
  logic             get_ready;
  logic             get_valid;
  logic [REQ_W-1:0] get_response;

  // Arbiter side.
  modport slave (
    input  imem_req_valid, imem_req, imem_resp_ready,
    input  dmem_req_valid, dmem_req, dmem_resp_ready,
    input  put_ready, get_ready, get_response,
    output imem_req_ready, imem_resp_valid, imem_resp,
    output dmem_req_ready, dmem_resp_valid, dmem_resp,
    output put_valid, put_request, get_valid
  );

  // Clients plus memory wrapper side.
  modport master (
    output imem_req_valid, imem_req, imem_resp_ready,
    output dmem_req_valid, dmem_req, dmem_resp_ready,
    output put_ready, get_ready, get_response,
    input  imem_req_ready, imem_resp_valid, imem_resp,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp,
    input  put_valid, put_request, get_valid
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client memory arbiter with an in-order route FIFO for responses.
// Define MEM_ARB_DMEM_PRIO_EN to give dmem fixed priority; default is round-robin.
module mem_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned REQ_W = 68
) (
  input  logic         CLK,
  input  logic         RST,
  mem_arbiter_if.slave bus,
  output logic         orphan_err
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] r_route;  // one client id per outstanding request
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_rr_ptr;
  logic             r_orphan;

  logic             w_full;
  logic             w_empty;
  logic             w_conflict_pick;
  logic             w_grant;
  logic             w_push;
  logic             w_pop;
  logic             w_head;
  logic             w_dest_ready;
  logic [REQ_W-1:0] w_put_request;

`ifdef MEM_ARB_DMEM_PRIO_EN
  assign w_conflict_pick = 1'b1;
`else
  assign w_conflict_pick = r_rr_ptr;
`endif

  always_comb begin
    w_full  = (r_count == FULL_CNT);
    w_empty = (r_count == '0);

    w_grant = r_rr_ptr;
    if (bus.imem_req_valid && !bus.dmem_req_valid) begin
      w_grant = 1'b0;
    end else if (!bus.imem_req_valid && bus.dmem_req_valid) begin
      w_grant = 1'b1;
    end else if (bus.imem_req_valid && bus.dmem_req_valid) begin
      w_grant = w_conflict_pick;
    end

    w_put_request       = w_grant ? bus.dmem_req : bus.imem_req;
    bus.put_request     = w_put_request;
    // Handshake outputs are forced low while reset is asserted.
    bus.put_valid       = !RST && (bus.imem_req_valid || bus.dmem_req_valid) && !w_full;
    bus.imem_req_ready  = !RST && bus.put_ready && !w_full && !w_grant;
    bus.dmem_req_ready  = !RST && bus.put_ready && !w_full && w_grant;
    w_push              = bus.put_valid && bus.put_ready;

    w_head              = r_route[r_rd_ptr];
    w_dest_ready        = w_head ? bus.dmem_resp_ready : bus.imem_resp_ready;
    bus.imem_resp_valid = !RST && bus.get_ready && !w_empty && !w_head;
    bus.dmem_resp_valid = !RST && bus.get_ready && !w_empty && w_head;
    bus.imem_resp       = bus.get_response;
    bus.dmem_resp       = bus.get_response;
    bus.get_valid       = !RST && bus.get_ready && !w_empty && w_dest_ready;
    w_pop               = bus.get_valid;

    orphan_err          = r_orphan;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_route  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rr_ptr <= 1'b0;
      r_orphan <= 1'b0;
    end else begin
      if (w_push) begin
        r_route[r_wr_ptr] <= w_grant;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
        r_rr_ptr          <= ~w_grant;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
      // A response offered with nothing outstanding has nowhere to go.
      if (bus.get_ready && w_empty) begin
        r_orphan <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// compared against a queue-based model of outstanding routes.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned REQ_W = 68;
`ifdef MEM_ARB_DMEM_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  logic orphan_err;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_arbiter_if #(.REQ_W(REQ_W)) bus ();

  mem_arbiter #(.DEPTH(DEPTH), .REQ_W(REQ_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .orphan_err(orphan_err)
  );

  always #5 CLK = ~CLK;

  // Model: queue of client ids awaiting a response, round-robin pointer, sticky error.
  int route_q[$];
  bit m_rr;
  bit m_orphan;
  int e_grant;
  bit e_put_valid, e_ireq_ready, e_dreq_ready, e_iresp_valid, e_dresp_valid, e_get_valid;
  logic [REQ_W-1:0] e_put_request;

  function automatic logic [REQ_W-1:0] mki(logic [31:0] a);
    return {4'hF, a, ~a};
  endfunction

  function automatic logic [REQ_W-1:0] mkd(logic [31:0] a);
    return {4'h3, a, a ^ 32'hDEAD_BEEF};
  endfunction

  function automatic logic [REQ_W-1:0] mkr(logic [31:0] d);
    return {4'h0, 32'h0, d};
  endfunction

  function automatic logic [6:0] obs_vec();
    return {bus.put_valid, bus.imem_req_ready, bus.dmem_req_ready, bus.imem_resp_valid,
            bus.dmem_resp_valid, bus.get_valid, orphan_err};
  endfunction

  function automatic logic [6:0] exp_vec();
    return {e_put_valid, e_ireq_ready, e_dreq_ready, e_iresp_valid, e_dresp_valid,
            e_get_valid, m_orphan};
  endfunction

  function automatic void predict();
    bit iv       = bus.imem_req_valid;
    bit dv       = bus.dmem_req_valid;
    bit full     = route_q.size() >= int'(DEPTH);
    bit nonempty = route_q.size() != 0;
    int head     = nonempty ? route_q[0] : 0;
    if (iv && !dv)      e_grant = 0;
    else if (dv && !iv) e_grant = 1;
    else if (iv && dv)  e_grant = PRIO ? 1 : int'(m_rr);
    else                e_grant = int'(m_rr);
    e_put_valid   = (iv || dv) && !full;
    e_ireq_ready  = bus.put_ready && !full && (e_grant == 0);
    e_dreq_ready  = bus.put_ready && !full && (e_grant == 1);
    e_put_request = (e_grant == 1) ? bus.dmem_req : bus.imem_req;
    e_iresp_valid = bus.get_ready && nonempty && (head == 0);
    e_dresp_valid = bus.get_ready && nonempty && (head == 1);
    e_get_valid   = bus.get_ready && nonempty &&
                    ((head == 1) ? bus.dmem_resp_ready : bus.imem_resp_ready);
  endfunction

  task automatic model_reset();
    route_q.delete();
    m_rr     = 1'b0;
    m_orphan = 1'b0;
  endtask

  task automatic set_all(bit v);
    bus.imem_req_valid  = v;
    bus.dmem_req_valid  = v;
    bus.imem_resp_ready = v;
    bus.dmem_resp_ready = v;
    bus.put_ready       = v;
    bus.get_ready       = v;
    bus.imem_req        = mki(32'h0);
    bus.dmem_req        = mkd(32'h0);
    bus.get_response    = mkr(32'h0);
  endtask

  task automatic drive(bit iv, logic [31:0] ia, bit dv, logic [31:0] da, bit pr, bit gr,
                       logic [31:0] gd, bit ir, bit dr);
    @(negedge CLK);
    bus.imem_req_valid  = iv;
    bus.imem_req        = mki(ia);
    bus.dmem_req_valid  = dv;
    bus.dmem_req        = mkd(da);
    bus.put_ready       = pr;
    bus.get_ready       = gr;
    bus.get_response    = mkr(gd);
    bus.imem_resp_ready = ir;
    bus.dmem_resp_ready = dr;
    #1;
    predict();
  endtask

  task automatic advance();
    bit push   = e_put_valid && bus.put_ready;
    bit pop    = e_get_valid;
    bit orphan = bus.get_ready && (route_q.size() == 0);
    @(posedge CLK);
    if (pop) void'(route_q.pop_front());
    if (push) begin
      route_q.push_back(e_grant);
      m_rr = (e_grant == 0);
    end
    if (orphan) m_orphan = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    set_all(1'b0);
    RST = 1'b1;
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1;
    model_reset();
    set_all(1'b1);
    #1;
    n_checks++;
    if (obs_vec() !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b want %b", obs_vec(), 7'b0);
    end
    @(posedge CLK);
    #1;
    n_checks++;
    if (obs_vec() !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_after_edge got %b want %b", obs_vec(), 7'b0);
    end
    @(negedge CLK);
    set_all(1'b0);
    RST = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    drive(1, 32'h0000_0100, 0, 0, 1, 0, 0, 0, 0);
    n_checks++;
    if ({bus.put_valid, bus.imem_req_ready, bus.dmem_req_ready} !== 3'b110) begin
      n_fail++;
      $display("FAIL single_handshake got %b want 110",
               {bus.put_valid, bus.imem_req_ready, bus.dmem_req_ready});
    end
    n_checks++;
    if (bus.put_request !== mki(32'h0000_0100)) begin
      n_fail++;
      $display("FAIL single_payload got %h want %h", bus.put_request, mki(32'h0000_0100));
    end
    advance();
    // One outstanding route: a response must go to imem.
    drive(0, 0, 0, 0, 0, 1, 32'h1234, 1, 0);
    n_checks++;
    if ({bus.imem_resp_valid, bus.dmem_resp_valid, bus.get_valid} !== 3'b101) begin
      n_fail++;
      $display("FAIL single_resp got %b want 101",
               {bus.imem_resp_valid, bus.dmem_resp_valid, bus.get_valid});
    end
    n_checks++;
    if (bus.imem_resp !== mkr(32'h1234)) begin
      n_fail++;
      $display("FAIL single_resp_data got %h want %h", bus.imem_resp, mkr(32'h1234));
    end
    advance();
  endtask

  task automatic test_round_robin();
    logic [3:0] want;
    want = PRIO ? 4'b1111 : 4'b1010;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h200 + i, 1, 32'h300 + i, 1, 0, 0, 0, 0);
      n_checks++;
      if ({bus.imem_req_ready, bus.dmem_req_ready} !== (want[i] ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL rr_grant[%0d] got %b want %b", i,
                 {bus.imem_req_ready, bus.dmem_req_ready}, want[i] ? 2'b01 : 2'b10);
      end
      n_checks++;
      if (bus.put_request !== (want[i] ? mkd(32'h300 + i) : mki(32'h200 + i))) begin
        n_fail++;
        $display("FAIL rr_payload[%0d] got %h", i, bus.put_request);
      end
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1, 32'h50 + i, 1, 1);
      n_checks++;
      if ({bus.imem_resp_valid, bus.dmem_resp_valid} !== (want[i] ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL rr_resp_route[%0d] got %b want %b", i,
                 {bus.imem_resp_valid, bus.dmem_resp_valid}, want[i] ? 2'b01 : 2'b10);
      end
      advance();
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h400 + i, 0, 0, 1, 0, 0, 0, 0);
      advance();
    end
    drive(1, 32'h404, 1, 32'h504, 1, 0, 0, 0, 0);
    n_checks++;
    if ({bus.put_valid, bus.imem_req_ready, bus.dmem_req_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL full_block got %b want 000",
               {bus.put_valid, bus.imem_req_ready, bus.dmem_req_ready});
    end
    advance();
    // Pop while full: no same-cycle push.
    drive(1, 32'h404, 1, 32'h504, 1, 1, 32'h77, 1, 1);
    n_checks++;
    if ({bus.put_valid, bus.imem_req_ready, bus.dmem_req_ready, bus.get_valid} !== 4'b0001) begin
      n_fail++;
      $display("FAIL full_no_bypass got %b want 0001",
               {bus.put_valid, bus.imem_req_ready, bus.dmem_req_ready, bus.get_valid});
    end
    advance();
    drive(1, 32'h404, 1, 32'h504, 1, 0, 0, 0, 0);
    n_checks++;
    if (bus.put_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_resume got %b want 1", bus.put_valid);
    end
    advance();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1, 32'h60 + i, 1, 1);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL full_drain[%0d] got %b want %b", i, obs_vec(), exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_resp_order();
    do_reset();
    drive(1, 32'h600, 0, 0, 1, 0, 0, 0, 0);
    advance();
    drive(0, 0, 1, 32'h700, 1, 0, 0, 0, 0);
    advance();
    drive(0, 0, 0, 0, 0, 1, 32'hAAAA, 0, 1);
    n_checks++;
    if ({bus.imem_resp_valid, bus.dmem_resp_valid, bus.get_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL order_stall got %b want 100",
               {bus.imem_resp_valid, bus.dmem_resp_valid, bus.get_valid});
    end
    advance();
    drive(0, 0, 0, 0, 0, 1, 32'hAAAA, 1, 1);
    n_checks++;
    if ({bus.imem_resp_valid, bus.dmem_resp_valid, bus.get_valid, bus.imem_resp} !==
        {3'b101, mkr(32'hAAAA)}) begin
      n_fail++;
      $display("FAIL order_first got %b/%h want 101/%h",
               {bus.imem_resp_valid, bus.dmem_resp_valid, bus.get_valid}, bus.imem_resp,
               mkr(32'hAAAA));
    end
    advance();
    drive(0, 0, 0, 0, 0, 1, 32'hBBBB, 1, 1);
    n_checks++;
    if ({bus.imem_resp_valid, bus.dmem_resp_valid, bus.get_valid, bus.dmem_resp} !==
        {3'b011, mkr(32'hBBBB)}) begin
      n_fail++;
      $display("FAIL order_second got %b/%h want 011/%h",
               {bus.imem_resp_valid, bus.dmem_resp_valid, bus.get_valid}, bus.dmem_resp,
               mkr(32'hBBBB));
    end
    advance();
  endtask

  task automatic test_orphan();
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 32'h99, 1, 1);
    n_checks++;
    if ({bus.get_valid, orphan_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL orphan_first got %b want 00", {bus.get_valid, orphan_err});
    end
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (orphan_err !== 1'b1) begin
        n_fail++;
        $display("FAIL orphan_sticky[%0d] got %b want 1", i, orphan_err);
      end
      advance();
    end
    do_reset();
    #1;
    n_checks++;
    if (orphan_err !== 1'b0) begin
      n_fail++;
      $display("FAIL orphan_cleared got %b want 0", orphan_err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h800 + i, 0, 0, 1, 0, 0, 0, 0);
      advance();
    end
    @(negedge CLK);
    set_all(1'b1);
    RST = 1'b1;
    #1;
    n_checks++;
    if (obs_vec() !== 7'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs got %b want %b", obs_vec(), 7'b0);
    end
    model_reset();
    @(negedge CLK);
    set_all(1'b0);
    RST = 1'b0;
    drive(1, 32'h900, 1, 32'hA00, 1, 0, 0, 0, 0);
    n_checks++;
    if ({bus.imem_req_ready, bus.dmem_req_ready} !== (PRIO ? 2'b01 : 2'b10)) begin
      n_fail++;
      $display("FAIL midreset_rr got %b want %b", {bus.imem_req_ready, bus.dmem_req_ready},
               PRIO ? 2'b01 : 2'b10);
    end
    advance();
    // Only the post-reset request may be routed.
    drive(0, 0, 0, 0, 0, 1, 32'h11, 1, 1);
    n_checks++;
    if ({bus.imem_resp_valid, bus.dmem_resp_valid} !== (PRIO ? 2'b01 : 2'b10)) begin
      n_fail++;
      $display("FAIL midreset_route got %b want %b",
               {bus.imem_resp_valid, bus.dmem_resp_valid}, PRIO ? 2'b01 : 2'b10);
    end
    advance();
    drive(0, 0, 0, 0, 0, 1, 32'h12, 1, 1);
    n_checks++;
    if (bus.get_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_empty got %b want 0", bus.get_valid);
    end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rand_handshake[%0d] got %b want %b", i, obs_vec(), exp_vec());
      end
      if (e_put_valid) begin
        n_checks++;
        if (bus.put_request !== e_put_request) begin
          n_fail++;
          $display("FAIL rand_payload[%0d] got %h want %h", i, bus.put_request, e_put_request);
        end
      end
      advance();
    end
  endtask

  initial begin
    RST = 1'b1;
    set_all(1'b0);
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_resp_order();
    test_orphan();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
